// File: rtl/rr_mux8_arbiter_pkg.sv
// Shared types and helpers for the 8-way round-robin channel arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rr_mux8_arbiter_pkg;

   localparam int NREQ = 8;
   localparam int SELW = 3;

   // Arbiter FSM encoding
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // One-hot decode of a requester index
   function automatic logic [NREQ-1:0] onehot8(input logic [SELW-1:0] idx);
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Round-robin pick: first set request searching from last+1 upward, wrapping to last.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever any is high.
module rr_pick8
   import rr_mux8_arbiter_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [SELW-1:0] last,
   output logic [SELW-1:0] pick,
   output logic            any
);

   logic [SELW-1:0]   base;
   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   logic [SELW-1:0]   off;

   // Rotate so that requester last+1 lands at bit 0; 3-bit add wraps mod 8
   always_comb begin
      base = last + 3'd1;
      dbl  = {req, req};
      rot  = dbl[base +: NREQ];
   end

   // Priority-encode the lowest set bit of the rotated vector, then un-rotate
   always_comb begin
      off = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = i[SELW-1:0];
         end
      end
      pick = base + off;
      any  = |req;
   end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter sharing one single-bit channel among 8 requesters, with hold limit.
// Latency: grant 1 cycle after request; din->dout combinational through the registered select.
// Backpressure: holder keeps the channel up to MAX_HOLD cycles, then others are served in turn.
module rr_mux8_arbiter
   import rr_mux8_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int CNTW     = 4
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] din,
   output logic [NREQ-1:0] grant,
   output logic [SELW-1:0] sel,
   output logic            valid,
   output logic            dout,
   output logic            busy
);

   // Last hold-counter value before the grant is forced back into arbitration
   localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);

   state_t          state, state_nxt;
   logic [NREQ-1:0] grant_nxt;
   logic [SELW-1:0] sel_nxt;
   logic [SELW-1:0] last, last_nxt;
   logic [CNTW-1:0] hold_cnt, hold_cnt_nxt;

   logic [SELW-1:0] pick;
   logic            any;
   logic            holder_req;
   logic            keep;

   // Next candidate always searches from the most recent winner
   rr_pick8 u_pick (
      .req  (req),
      .last (last),
      .pick (pick),
      .any  (any)
   );

   // Register the FSM, grant, select, priority pointer and hold counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         sel      <= '0;
         last     <= 3'd7;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         sel      <= sel_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

   // Decide keep / re-arbitrate / go idle; re-arbitration has no idle bubble
   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      sel_nxt      = sel;
      last_nxt     = last;
      hold_cnt_nxt = hold_cnt;
      holder_req   = req[sel];
      keep         = holder_req && (hold_cnt < HOLD_LAST);

      unique case (state)
         IDLE: begin
            if (any) begin
               state_nxt    = GRANT;
               grant_nxt    = onehot8(pick);
               sel_nxt      = pick;
               last_nxt     = pick;
               hold_cnt_nxt = '0;
            end
         end
         GRANT: begin
            if (keep) begin
               hold_cnt_nxt = hold_cnt + CNTW'(1);
            end else if (any) begin
               // last equals sel here, so the current holder is checked last
               grant_nxt    = onehot8(pick);
               sel_nxt      = pick;
               last_nxt     = pick;
               hold_cnt_nxt = '0;
            end else begin
               // sel is left untouched so it still names the previous holder
               state_nxt    = IDLE;
               grant_nxt    = '0;
               hold_cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt    = IDLE;
            grant_nxt    = '0;
            hold_cnt_nxt = '0;
         end
      endcase
   end

   // Channel outputs: a dropped request kills valid in the same cycle
   always_comb begin
      busy  = (state == GRANT);
      valid = busy & req[sel];
      dout  = valid & din[sel];
   end

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Scoreboarded random + directed bench for rr_mux8_arbiter against a queue-free holder model.
// Latency: expectations are pushed per cycle and popped on the falling edge.
// Backpressure: not applicable.
module tb_rr_mux8_arbiter;

   localparam int MAX_HOLD = 4;
   localparam int CNTW     = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] din;
   logic [7:0] grant;
   logic [2:0] sel;
   logic       valid;
   logic       dout;
   logic       busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] grant;
      logic [2:0] sel;
      logic       valid;
      logic       dout;
      logic       busy;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   cyc_no = 0;

   // Reference model: who holds the channel, for how many cycles, and who won last
   int         m_holder;   // -1 when idle
   int         m_held;     // cycles the current holder has owned the channel
   int         m_last;
   logic [2:0] m_sel;

   rr_mux8_arbiter #(.MAX_HOLD(MAX_HOLD), .CNTW(CNTW)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .din   (din),
      .grant (grant),
      .sel   (sel),
      .valid (valid),
      .dout  (dout),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   function automatic int rr_pick(input logic [7:0] r, input int last);
      for (int k = 1; k <= 8; k++) begin
         int idx;
         idx = (last + k) % 8;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_holder = -1;
      m_held   = 0;
      m_last   = 7;
      m_sel    = 3'd0;
   endtask

   // Advance the model by one clock edge using the request vector the DUT sampled
   task automatic model_edge(input logic [7:0] r);
      int p;
      if (m_holder >= 0 && r[m_holder] && m_held < MAX_HOLD) begin
         m_held++;
      end else begin
         p = rr_pick(r, m_last);
         if (p >= 0) begin
            m_holder = p;
            m_last   = p;
            m_held   = 1;
            m_sel    = p[2:0];
         end else begin
            m_holder = -1;
            m_held   = 0;
         end
      end
   endtask

   task automatic push_exp(input logic [7:0] r, input logic [7:0] d);
      exp_t e;
      e.busy  = (m_holder >= 0);
      e.grant = e.busy ? (8'h01 << m_holder) : 8'h00;
      e.sel   = m_sel;
      e.valid = e.busy && r[m_holder];
      e.dout  = e.valid && d[m_holder];
      e.cyc   = cyc_no;
      q.push_back(e);
   endtask

   // One clock of stimulus: model sees the old inputs at the edge, then new inputs apply
   task automatic step(input logic [7:0] r, input logic [7:0] d);
      @(posedge clk);
      model_edge(req);
      #2;
      req = r;
      din = d;
      cyc_no++;
      push_exp(r, d);
   endtask

   task automatic check_now(input string name, input logic [14:0] act, input logic [14:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got grant=%h sel=%0d valid=%b dout=%b busy=%b, want grant=%h sel=%0d valid=%b dout=%b busy=%b",
                  name, act[14:7], act[6:4], act[3], act[2], act[1], want[14:7], want[6:4], want[3], want[2], want[1]);
      end
   endtask

   // Monitor: compare the DUT against the oldest outstanding expectation
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check_now($sformatf("cycle%0d", e.cyc),
                   {grant, sel, valid, dout, busy, 1'b0},
                   {e.grant, e.sel, e.valid, e.dout, e.busy, 1'b0});
      end
   end

   initial begin
      logic [7:0] r;
      int         wait_cnt;

      rst = 1'b1;
      req = 8'h00;
      din = 8'h00;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_now("reset_state", {grant, sel, valid, dout, busy, 1'b0}, 15'd0);
      rst = 1'b0;

      // First grant to requester 0 one edge after request, data forwarded
      step(8'h01, 8'h01);
      step(8'h01, 8'h01);
      step(8'h01, 8'h00);
      step(8'h00, 8'h00);
      step(8'h00, 8'h00);

      // All requesting: strict rotation, MAX_HOLD cycles each, no idle gaps
      for (int i = 0; i < 40; i++) step(8'hFF, 8'(i * 37));

      // Requester 3 alone, then it drops while 5 asks
      for (int i = 0; i < 3; i++) step(8'h08, 8'h08);
      step(8'h20, 8'h28);
      step(8'h20, 8'h20);
      step(8'h20, 8'h00);

      // Lone requester 2 keeps being re-granted across hold expiries
      for (int i = 0; i < 10; i++) step(8'h04, 8'(i));

      // Request vanishes during a grant: back to idle with sel retained
      step(8'h00, 8'hFF);
      step(8'h00, 8'hFF);

      // Asynchronous reset in the middle of a grant to requester 6
      step(8'h40, 8'h40);
      step(8'h40, 8'h40);
      step(8'h40, 8'h40);
      @(negedge clk);
      #2;
      req = 8'hC1;
      rst = 1'b1;
      #1;
      check_now("async_reset_clear", {grant, sel, valid, dout, busy, 1'b0}, 15'd0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      model_reset();
      push_exp(req, din);
      step(8'hC1, 8'h01);
      step(8'hC1, 8'h01);

      // Random traffic with sticky requests and occasional silence
      r = 8'h00;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 5))
            0:       r = 8'h00;
            1, 2:    r = r;
            3:       r = r ^ (8'h01 << $urandom_range(0, 7));
            default: r = 8'($urandom);
         endcase
         step(r, 8'($urandom));
      end
      step(8'h00, 8'h00);

      wait_cnt = 0;
      while (q.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
